mips_multicycle_control: RTL and testbench

// Main control FSM for the multi-cycle MIPS datapath. Decodes IR opcode/funct, drives the

---
 rtl/mips_multicycle_control_pkg.sv | 105 ++++++++++
 rtl/mips_multicycle_control_decode.sv | 87 ++++++++
 rtl/mips_multicycle_control.sv | 218 +++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: FSM states,
// opcode/funct constants, ALU operation codes and datapath mux selects.
package mips_multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_JR       = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  // Coarse instruction class used to pick the post-decode path.
  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_JR      = 3'd1,
    CLS_JUMP    = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_IMM     = 3'd4,
    CLS_LOAD    = 3'd5,
    CLS_STORE   = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // ALU control opcodes
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b11;

  // Memory access size
  localparam logic [1:0] MEM_SIZE_WORD = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b10;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG_A  = 2'b11;

  // ALU operand selects
  localparam logic       ALU_A_PC      = 1'b0;
  localparam logic       ALU_A_REG     = 1'b1;
  localparam logic [1:0] ALU_B_REG     = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_B_BR_OFS  = 2'b11;

  // Immediate extension select
  localparam logic [1:0] EXT_SIGN  = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  // Register file destination / write-data selects
  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;
  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

endpackage

// File: rtl/mips_multicycle_control_decode.sv
// Combinational opcode/funct classifier: instruction class, memory access
// size, immediate extension mode and the ALU funct substituted for I-type ops.
module mips_instr_class_decode
  import mips_multicycle_control_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic [1:0]   mem_size,
  output logic [1:0]   ext_sel,
  output logic [5:0]   imm_funct
);

  // Classify the instruction held in IR
  always_comb begin
    cls       = CLS_ILLEGAL;
    mem_size  = MEM_SIZE_WORD;
    ext_sel   = EXT_SIGN;
    imm_funct = FN_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_JR: cls = CLS_JR;
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLL, FN_SRL: cls = CLS_R;
          default: cls = CLS_ILLEGAL;
        endcase
      end
      OP_J, OP_JAL:    cls = CLS_JUMP;
      OP_BEQ, OP_BNE:  cls = CLS_BRANCH;
      OP_ADDI, OP_ADDIU: begin
        cls       = CLS_IMM;
        imm_funct = FN_ADD;
      end
      OP_SLTI: begin
        cls       = CLS_IMM;
        imm_funct = FN_SLT;
      end
      OP_SLTIU: begin
        cls       = CLS_IMM;
        imm_funct = FN_SLTU;
      end
      OP_ANDI: begin
        cls       = CLS_IMM;
        imm_funct = FN_AND;
        ext_sel   = EXT_ZERO;
      end
      OP_ORI: begin
        cls       = CLS_IMM;
        imm_funct = FN_OR;
        ext_sel   = EXT_ZERO;
      end
      OP_LUI: begin
        // LUI adds the shifted immediate to $zero (rs field is 0)
        cls       = CLS_IMM;
        imm_funct = FN_ADD;
        ext_sel   = EXT_UPPER;
      end
      OP_LW: begin
        cls      = CLS_LOAD;
        mem_size = MEM_SIZE_WORD;
      end
      OP_LHU: begin
        cls      = CLS_LOAD;
        mem_size = MEM_SIZE_HALF;
      end
      OP_LBU: begin
        cls      = CLS_LOAD;
        mem_size = MEM_SIZE_BYTE;
      end
      OP_SW: begin
        cls      = CLS_STORE;
        mem_size = MEM_SIZE_WORD;
      end
      OP_SH: begin
        cls      = CLS_STORE;
        mem_size = MEM_SIZE_HALF;
      end
      OP_SB: begin
        cls      = CLS_STORE;
        mem_size = MEM_SIZE_BYTE;
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath. Moore-decoded outputs;
// only the memory-access states look at mem_ready. While reset is high every
// enable and select is held at 0 so an abandoned instruction writes nothing.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic [1:0] mem_size,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_eq,
  output logic       pc_write_ne,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ext_sel,
  output logic [1:0] alu_op,
  output logic [5:0] alu_funct,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t       state, next_state;
  instr_class_t cls;
  logic [1:0]   dec_mem_size;
  logic [1:0]   dec_ext_sel;
  logic [5:0]   dec_imm_funct;
  logic         set_illegal;

  mips_instr_class_decode u_decode (
    .opcode    (opcode),
    .funct     (funct),
    .cls       (cls),
    .mem_size  (dec_mem_size),
    .ext_sel   (dec_ext_sel),
    .imm_funct (dec_imm_funct)
  );

  assign state_dbg   = state;
  // Flag rises together with the entry into the trap state and then sticks
  assign set_illegal = (next_state == S_TRAP);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Sticky illegal-instruction flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset)            illegal_op <= 1'b0;
    else if (set_illegal) illegal_op <= 1'b1;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (cls)
          CLS_R:      next_state = S_R_EXEC;
          CLS_JR:     next_state = S_JR;
          CLS_JUMP:   next_state = S_JUMP;
          CLS_BRANCH: next_state = S_BRANCH;
          CLS_IMM:    next_state = S_I_EXEC;
          CLS_LOAD,
          CLS_STORE:  next_state = S_MEM_ADDR;
          default:    next_state = S_TRAP;
        endcase
      end
      S_MEM_ADDR: next_state = (cls == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   next_state = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   next_state = S_FETCH;
      S_MEM_WR:   next_state = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   next_state = S_R_WB;
      S_R_WB:     next_state = S_FETCH;
      S_I_EXEC:   next_state = S_I_WB;
      S_I_WB:     next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
      S_JR:       next_state = S_FETCH;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_FETCH;
    endcase
  end

  // Moore output decode, all zero while reset is asserted
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    mem_size    = MEM_SIZE_WORD;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    pc_source   = PC_SRC_ALU;
    alu_src_a   = ALU_A_PC;
    alu_src_b   = ALU_B_REG;
    ext_sel     = EXT_SIGN;
    alu_op      = ALU_OP_ADD;
    alu_funct   = 6'b000000;
    reg_write   = 1'b0;
    reg_dst     = REG_DST_RT;
    mem_to_reg  = MTR_ALUOUT;
    instr_done  = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          // PC+4 computed by the ALU and written back when the fetch completes
          mem_req   = 1'b1;
          iord      = 1'b0;
          alu_src_a = ALU_A_PC;
          alu_src_b = ALU_B_FOUR;
          alu_op    = ALU_OP_ADD;
          pc_source = PC_SRC_ALU;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          // Speculative branch target into ALUOut
          alu_src_a = ALU_A_PC;
          alu_src_b = ALU_B_BR_OFS;
          alu_op    = ALU_OP_ADD;
        end
        S_R_EXEC: begin
          alu_src_a = ALU_A_REG;
          alu_src_b = ALU_B_REG;
          alu_op    = ALU_OP_FUNCT;
          alu_funct = funct;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = REG_DST_RD;
          mem_to_reg = MTR_ALUOUT;
          instr_done = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a = ALU_A_REG;
          alu_src_b = ALU_B_IMM;
          alu_op    = ALU_OP_FUNCT;
          alu_funct = dec_imm_funct;
          ext_sel   = dec_ext_sel;
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          reg_dst    = REG_DST_RT;
          mem_to_reg = MTR_ALUOUT;
          instr_done = 1'b1;
        end
        S_MEM_ADDR: begin
          alu_src_a = ALU_A_REG;
          alu_src_b = ALU_B_IMM;
          ext_sel   = EXT_SIGN;
          alu_op    = ALU_OP_ADD;
          mem_size  = dec_mem_size;
        end
        S_MEM_RD: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          mem_size = dec_mem_size;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          reg_dst    = REG_DST_RT;
          mem_to_reg = MTR_MDR;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_req    = 1'b1;
          mem_write  = 1'b1;
          iord       = 1'b1;
          mem_size   = dec_mem_size;
          instr_done = mem_ready;
        end
        S_BRANCH: begin
          alu_src_a   = ALU_A_REG;
          alu_src_b   = ALU_B_REG;
          alu_op      = ALU_OP_SUB;
          pc_source   = PC_SRC_ALUOUT;
          pc_write_eq = (opcode == OP_BEQ);
          pc_write_ne = (opcode == OP_BNE);
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          // PC already holds PC+4, so JAL links straight from it
          pc_source  = PC_SRC_JUMP;
          pc_write   = 1'b1;
          instr_done = 1'b1;
          if (opcode == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = REG_DST_RA;
            mem_to_reg = MTR_PC;
          end
        end
        S_JR: begin
          pc_source  = PC_SRC_REG_A;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control. Each instruction is expanded
// into a per-cycle list of expected outputs derived from its execution
// sequence; one compare step checks every output on every cycle.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_write, pc_write_eq, pc_write_ne;
  logic [1:0] mem_size, pc_source, alu_src_b, ext_sel, alu_op, reg_dst, mem_to_reg;
  logic       alu_src_a, reg_write, instr_done, illegal_op;
  logic [5:0] alu_funct;
  logic [3:0] state_dbg;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .mem_size(mem_size), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_eq(pc_write_eq),
    .pc_write_ne(pc_write_ne), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_sel(ext_sel), .alu_op(alu_op), .alu_funct(alu_funct),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .instr_done(instr_done), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op, fn;
    logic       rdy, rst;
    logic [3:0] st;
    logic       req, wr;
    logic [1:0] size;
    logic       iord, irw, pcw, peq, pne;
    logic [1:0] psrc;
    logic       asrc;
    logic [1:0] bsrc, ext, aop;
    logic [5:0] afn;
    logic       rw;
    logic [1:0] rdst, m2r;
    logic       done, ill;
  } rec_t;

  rec_t q[$];
  logic ill_m;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  function automatic rec_t blank(input logic [5:0] op, input logic [5:0] fn,
                                 input logic [3:0] st, input logic rdy);
    rec_t r;
    r.op = op; r.fn = fn; r.rdy = rdy; r.rst = 1'b0; r.st = st;
    r.req = 0; r.wr = 0; r.size = 0; r.iord = 0; r.irw = 0; r.pcw = 0;
    r.peq = 0; r.pne = 0; r.psrc = 0; r.asrc = 0; r.bsrc = 0; r.ext = 0;
    r.aop = 0; r.afn = 0; r.rw = 0; r.rdst = 0; r.m2r = 0; r.done = 0;
    r.ill = ill_m;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cyc%0d %s: got %0h expected %0h", cyc, name, act, exp);
    end
  endtask

  task automatic push_reset(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] st);
    rec_t r;
    r = blank(op, fn, st, 1'b1);
    r.rst = 1'b1;
    q.push_back(r);
  endtask

  task automatic add_fetch(input logic [5:0] op, input logic [5:0] fn, input int fw);
    rec_t r;
    for (int i = 0; i <= fw; i++) begin
      r = blank(op, fn, 4'd0, (i == fw));
      r.req = 1'b1; r.bsrc = 2'b01;
      r.irw = (i == fw); r.pcw = (i == fw);
      q.push_back(r);
    end
  endtask

  // Expand one instruction into its expected cycles; fw/mw are wait cycles
  // inserted before mem_ready rises in fetch / data access.
  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    rec_t r;
    logic [1:0] sz;
    add_fetch(op, fn, fw);
    r = blank(op, fn, 4'd1, 1'b1); r.bsrc = 2'b11; q.push_back(r);
    sz = (op == 6'd35 || op == 6'd43) ? 2'b00 : (op == 6'd37 || op == 6'd41) ? 2'b01 : 2'b10;
    if (op == 6'd0 && fn == 6'b001000) begin
      r = blank(op, fn, 4'd12, 1'b1); r.psrc = 2'b11; r.pcw = 1; r.done = 1; q.push_back(r);
    end else if (op == 6'd0 && (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                           6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02})) begin
      r = blank(op, fn, 4'd6, 1'b1); r.asrc = 1; r.aop = 2'b11; r.afn = fn; q.push_back(r);
      r = blank(op, fn, 4'd7, 1'b1); r.rw = 1; r.rdst = 2'b01; r.done = 1; q.push_back(r);
    end else if (op == 6'd2 || op == 6'd3) begin
      r = blank(op, fn, 4'd9, 1'b1); r.psrc = 2'b10; r.pcw = 1; r.done = 1;
      if (op == 6'd3) begin r.rw = 1; r.rdst = 2'b10; r.m2r = 2'b10; end
      q.push_back(r);
    end else if (op == 6'd4 || op == 6'd5) begin
      r = blank(op, fn, 4'd8, 1'b1); r.asrc = 1; r.aop = 2'b01; r.psrc = 2'b01;
      r.peq = (op == 6'd4); r.pne = (op == 6'd5); r.done = 1; q.push_back(r);
    end else if (op inside {6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd15}) begin
      r = blank(op, fn, 4'd10, 1'b1); r.asrc = 1; r.bsrc = 2'b10; r.aop = 2'b11;
      case (op)
        6'd10:   r.afn = 6'b101010;
        6'd11:   r.afn = 6'b101011;
        6'd12:   r.afn = 6'b100100;
        6'd13:   r.afn = 6'b100101;
        default: r.afn = 6'b100000;
      endcase
      r.ext = (op == 6'd12 || op == 6'd13) ? 2'b01 : (op == 6'd15) ? 2'b10 : 2'b00;
      q.push_back(r);
      r = blank(op, fn, 4'd11, 1'b1); r.rw = 1; r.done = 1; q.push_back(r);
    end else if (op inside {6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43}) begin
      r = blank(op, fn, 4'd2, 1'b1); r.asrc = 1; r.bsrc = 2'b10; r.size = sz; q.push_back(r);
      for (int i = 0; i <= mw; i++) begin
        if (op inside {6'd35, 6'd36, 6'd37}) begin
          r = blank(op, fn, 4'd3, (i == mw)); r.req = 1; r.iord = 1; r.size = sz;
        end else begin
          r = blank(op, fn, 4'd5, (i == mw)); r.req = 1; r.wr = 1; r.iord = 1; r.size = sz;
          r.done = (i == mw);
        end
        q.push_back(r);
      end
      if (op inside {6'd35, 6'd36, 6'd37}) begin
        r = blank(op, fn, 4'd4, 1'b1); r.rw = 1; r.m2r = 2'b01; r.done = 1; q.push_back(r);
      end
    end else begin
      ill_m = 1'b1;
      for (int i = 0; i < 3; i++) begin
        r = blank(op, fn, 4'd13, 1'b1);
        q.push_back(r);
      end
    end
  endtask

  task automatic compare(input rec_t r);
    chk("state_dbg",   8'(state_dbg),   8'(r.st));
    chk("mem_req",     8'(mem_req),     8'(r.req));
    chk("mem_write",   8'(mem_write),   8'(r.wr));
    chk("mem_size",    8'(mem_size),    8'(r.size));
    chk("iord",        8'(iord),        8'(r.iord));
    chk("ir_write",    8'(ir_write),    8'(r.irw));
    chk("pc_write",    8'(pc_write),    8'(r.pcw));
    chk("pc_write_eq", 8'(pc_write_eq), 8'(r.peq));
    chk("pc_write_ne", 8'(pc_write_ne), 8'(r.pne));
    chk("pc_source",   8'(pc_source),   8'(r.psrc));
    chk("alu_src_a",   8'(alu_src_a),   8'(r.asrc));
    chk("alu_src_b",   8'(alu_src_b),   8'(r.bsrc));
    chk("ext_sel",     8'(ext_sel),     8'(r.ext));
    chk("alu_op",      8'(alu_op),      8'(r.aop));
    chk("alu_funct",   8'(alu_funct),   8'(r.afn));
    chk("reg_write",   8'(reg_write),   8'(r.rw));
    chk("reg_dst",     8'(reg_dst),     8'(r.rdst));
    chk("mem_to_reg",  8'(mem_to_reg),  8'(r.m2r));
    chk("instr_done",  8'(instr_done),  8'(r.done));
    chk("illegal_op",  8'(illegal_op),  8'(r.ill));
  endtask

  initial begin
    int   base;
    rec_t last;
    reset = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0; ill_m = 1'b0;

    push_reset(6'd0, 6'd0, 4'd0);
    push_reset(6'd0, 6'd0, 4'd0);

    // ADD: states 0,1,6,7, writeback to rd
    base = q.size();
    add_instr(6'b000000, 6'b100000, 0, 0);
    chk("model add length", 8'(q.size() - base), 8'd4);
    chk("model add st2",    8'(q[base + 2].st), 8'd6);
    chk("model add st3",    8'(q[base + 3].st), 8'd7);
    chk("model add rdst",   8'(q[base + 3].rdst), 8'h01);

    add_instr(6'b000000, 6'b100010, 1, 0);        // SUB with one fetch wait

    // LW with two data waits: 7 cycles, mem_req held 3 cycles in MEM_RD
    base = q.size();
    add_instr(6'b100011, 6'd0, 0, 2);
    chk("model lw length", 8'(q.size() - base), 8'd7);
    chk("model lw req",    8'(q[base + 3].req + q[base + 4].req + q[base + 5].req), 8'd3);

    add_instr(6'b101011, 6'd0, 0, 1);             // SW with one wait

    // BNE branch state
    base = q.size();
    add_instr(6'b000101, 6'd0, 0, 0);
    chk("model bne pne",  8'(q[base + 2].pne), 8'd1);
    chk("model bne aop",  8'(q[base + 2].aop), 8'h01);
    chk("model bne psrc", 8'(q[base + 2].psrc), 8'h01);
    add_instr(6'b000100, 6'd0, 0, 0);             // BEQ

    // ORI: zero-extended OR
    base = q.size();
    add_instr(6'b001101, 6'd0, 0, 0);
    chk("model ori afn", 8'(q[base + 2].afn), 8'h25);
    chk("model ori ext", 8'(q[base + 2].ext), 8'h01);
    add_instr(6'b001111, 6'd0, 0, 0);             // LUI
    add_instr(6'b001011, 6'd0, 0, 0);             // SLTIU
    add_instr(6'b001100, 6'd0, 2, 0);             // ANDI
    add_instr(6'b001000, 6'd0, 0, 0);             // ADDI
    add_instr(6'b001010, 6'd0, 0, 0);             // SLTI
    add_instr(6'b000010, 6'd0, 0, 0);             // J

    // JAL links to $31 from PC
    base = q.size();
    add_instr(6'b000011, 6'd0, 0, 0);
    chk("model jal rdst", 8'(q[base + 2].rdst), 8'h02);
    chk("model jal m2r",  8'(q[base + 2].m2r), 8'h02);
    add_instr(6'b000000, 6'b001000, 0, 0);        // JR
    add_instr(6'b100100, 6'd0, 0, 0);             // LBU
    add_instr(6'b100101, 6'd0, 0, 1);             // LHU
    add_instr(6'b101000, 6'd0, 0, 0);             // SB
    add_instr(6'b101001, 6'd0, 1, 2);             // SH
    add_instr(6'b000000, 6'b000000, 0, 0);        // SLL
    add_instr(6'b000000, 6'b100111, 0, 0);        // NOR

    // SW abandoned by reset in MEM_WR while memory is ready
    add_instr(6'b101011, 6'd0, 0, 0);
    last = q.pop_back();
    push_reset(last.op, last.fn, 4'd5);
    add_instr(6'b000000, 6'b100001, 0, 0);        // ADDU

    // Undefined opcode traps; flag sticky until reset
    add_instr(6'b111111, 6'd0, 0, 0);
    push_reset(6'b111111, 6'd0, 4'd13);
    ill_m = 1'b0;

    // Undefined R-type funct also traps
    add_instr(6'b000000, 6'b000001, 0, 0);
    push_reset(6'b000000, 6'b000001, 4'd13);
    ill_m = 1'b0;

    add_instr(6'b000000, 6'b101011, 0, 0);        // SLTU

    // Drive and check every cycle
    foreach (q[i]) begin
      @(posedge clk);
      #1;
      reset     = q[i].rst;
      mem_ready = q[i].rdy;
      opcode    = q[i].op;
      funct     = q[i].fn;
      #3;
      cyc = i;
      compare(q[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
